// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared state encoding and width helper for the memory game
//
// Purpose: state_t enum used by memory_game_ctrl and the renderer, plus a
//          clog2 helper that never returns less than one bit.
// Ports:   none (package).

package memory_game_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SHOW       = 4'd1,
    HIDE       = 4'd2,
    SHUFFLE    = 4'd3,
    GAME_START = 4'd4,
    PICK1      = 4'd5,
    PICK2      = 4'd6,
    RANDOM     = 4'd7,
    VERIFY     = 4'd8,
    CHECK      = 4'd9,
    DONE       = 4'd10
  } state_t;

  localparam int STATE_W = 4;

  // Bits needed to hold values 0..n-1, at least 1.
  function automatic int clog2_min1(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn tick down-counter with zero flag
//
// Purpose: loads TURN_TICKS on load, counts down on tick while en is high,
//          holds at zero.
// Ports:   clk, rst (async, active-high); load, en, tick in;
//          count [CNT_W-1:0] out (remaining ticks); zero out (count == 0).

module turn_timer #(
  parameter int TURN_TICKS = 15,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(TURN_TICKS);
    end else if (en && tick && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - card-matching game sequencer for N players and P pairs
//
// Purpose: runs setup (show/hide/shuffle), player turns with a per-turn
//          countdown, scoring, and the winner decision.
// Ports:   clk, rst (async, active-high);
//          start, tick, card_pick, show_done, hide_done, shuffle_done,
//          random_done, verify_done, pair_match in;
//          state [3:0], turn [PID_W-1:0], scores [NUM_PLAYERS*SCORE_W-1:0],
//          time_left [TIME_W-1:0], winner_valid, winner_id [PID_W-1:0], tie out.
// Build option: EXTRA_TURN_ON_MATCH_EN - a matching player keeps the turn.

module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  parameter int SCORE_W     = 4,
  parameter int TURN_TICKS  = 15,
  parameter int PID_W       = clog2_min1(NUM_PLAYERS),
  parameter int TIME_W      = clog2_min1(TURN_TICKS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           tick,
  input  logic                           card_pick,
  input  logic                           show_done,
  input  logic                           hide_done,
  input  logic                           shuffle_done,
  input  logic                           random_done,
  input  logic                           verify_done,
  input  logic                           pair_match,
  output logic [3:0]                     state,
  output logic [PID_W-1:0]               turn,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [TIME_W-1:0]              time_left,
  output logic                           winner_valid,
  output logic [PID_W-1:0]               winner_id,
  output logic                           tie
);

  localparam int MATCH_W = clog2_min1(NUM_PAIRS + 1);

  state_t                           state_q, state_d;
  logic [PID_W-1:0]                 turn_q, turn_d;
  logic [NUM_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
  logic [MATCH_W-1:0]               matched_q, matched_d;
  logic                             winner_valid_q, winner_valid_d;
  logic [PID_W-1:0]                 winner_id_q, winner_id_d;
  logic                             tie_q, tie_d;
`ifdef EXTRA_TURN_ON_MATCH_EN
  logic                             last_match_q, last_match_d;
`else
`endif

  logic             tmr_load, tmr_en, tmr_zero;
  logic [PID_W-1:0] next_turn;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] best_score;
  logic [PID_W-1:0]   best_id;
  logic               best_tie;

  // Reload on every entry into PICK1; PICK1->PICK2 keeps the running count.
  assign tmr_load = (state_d == PICK1) && (state_q != PICK1);
  assign tmr_en   = (state_q == PICK1) || (state_q == PICK2);

  turn_timer #(
    .TURN_TICKS (TURN_TICKS),
    .CNT_W      (TIME_W)
  ) u_turn_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (tmr_en),
    .tick  (tick),
    .count (time_left),
    .zero  (tmr_zero)
  );

  assign next_turn = (turn_q == PID_W'(NUM_PLAYERS - 1)) ? '0 : turn_q + PID_W'(1);
  assign cur_score = scores_q[int'(turn_q)*SCORE_W +: SCORE_W];

  // Lowest index wins on equal scores; tie flags more than one holder of the max.
  always_comb begin
    int n_max;
    best_score = scores_q[0 +: SCORE_W];
    best_id    = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_q[i*SCORE_W +: SCORE_W] > best_score) begin
        best_score = scores_q[i*SCORE_W +: SCORE_W];
        best_id    = PID_W'(i);
      end
    end
    n_max = 0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (scores_q[i*SCORE_W +: SCORE_W] == best_score) n_max = n_max + 1;
    end
    best_tie = (n_max > 1);
  end

  always_comb begin
    state_d        = state_q;
    turn_d         = turn_q;
    scores_d       = scores_q;
    matched_d      = matched_q;
    winner_valid_d = winner_valid_q;
    winner_id_d    = winner_id_q;
    tie_d          = tie_q;
`ifdef EXTRA_TURN_ON_MATCH_EN
    last_match_d   = last_match_q;
`else
`endif
    case (state_q)
      IDLE: begin
        turn_d         = '0;
        scores_d       = '0;
        matched_d      = '0;
        winner_valid_d = 1'b0;
        if (start) state_d = SHOW;
      end
      SHOW:       if (show_done)    state_d = HIDE;
      HIDE:       if (hide_done)    state_d = SHUFFLE;
      SHUFFLE:    if (shuffle_done) state_d = GAME_START;
      GAME_START: state_d = PICK1;
      // card_pick takes priority over an expired timer in the same cycle.
      PICK1: begin
        if (card_pick)     state_d = PICK2;
        else if (tmr_zero) state_d = RANDOM;
      end
      PICK2: begin
        if (card_pick)     state_d = VERIFY;
        else if (tmr_zero) state_d = RANDOM;
      end
      RANDOM:     if (random_done)  state_d = VERIFY;
      VERIFY: begin
        if (verify_done) begin
          if (pair_match) begin
            if (cur_score != '1) begin
              scores_d[int'(turn_q)*SCORE_W +: SCORE_W] = cur_score + SCORE_W'(1);
            end
            matched_d = matched_q + MATCH_W'(1);
          end
`ifdef EXTRA_TURN_ON_MATCH_EN
          last_match_d = pair_match;
`else
`endif
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (matched_q == MATCH_W'(NUM_PAIRS)) begin
          winner_id_d    = best_id;
          tie_d          = best_tie;
          winner_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
`ifdef EXTRA_TURN_ON_MATCH_EN
          if (!last_match_q) turn_d = next_turn;
`else
          turn_d = next_turn;
`endif
          state_d = PICK1;
        end
      end
      DONE: begin
        if (start) begin
          winner_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      turn_q         <= '0;
      scores_q       <= '0;
      matched_q      <= '0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= '0;
      tie_q          <= 1'b0;
`ifdef EXTRA_TURN_ON_MATCH_EN
      last_match_q   <= 1'b0;
`else
`endif
    end else begin
      state_q        <= state_d;
      turn_q         <= turn_d;
      scores_q       <= scores_d;
      matched_q      <= matched_d;
      winner_valid_q <= winner_valid_d;
      winner_id_q    <= winner_id_d;
      tie_q          <= tie_d;
`ifdef EXTRA_TURN_ON_MATCH_EN
      last_match_q   <= last_match_d;
`else
`endif
    end
  end

  assign state        = state_q;
  assign turn         = turn_q;
  assign scores       = scores_q;
  assign winner_valid = winner_valid_q;
  assign winner_id    = winner_id_q;
  assign tie          = tie_q;

endmodule
